m_bitmap_pixel_stream: RTL and testbench
========================================

M_BITMAP_PIXEL_STREAM -- requirements
Module: m_bitmap_pixel_stream

Interface
REQ-001 SHALL have parameter: MAX_DIM, 'd1024, largest accepted PixWidth/PixHeight.
REQ-002 SHALL have parameter: MIN_OFFSET, 'd54, smallest accepted PixArrayOffset.
REQ-003 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: StreamEn  in  1  start/hold request; low aborts and re-arms.
REQ-006 SHALL have ports: PixArrayOffset, PixWidth and PixHeight, each in 16, the header fields from the header checker, stable while StreamEn is high.
REQ-007 SHALL have ports: ByteValid  in  1, ByteData  in  8 and ByteReady  out  1, carrying the file byte stream from file byte 0; a byte transfers when ByteValid & ByteReady.
REQ-008 SHALL have ports: PixValid  out  1, PixData  out  24 ({R,G,B}), PixX  out  16, PixY  out  16 and PixReady  in  1; a pixel transfers when PixValid & PixReady.
REQ-009 SHALL have ports: StreamComplite  out  1 (done) and StreamFail  out  1 (rejected parameters).

Function
REQ-010 SHALL implement states S_IDLE, S_CHECK, S_SKIP, S_BYTE_B, S_BYTE_G, S_BYTE_R, S_PIX_OUT, S_PAD, S_FAIL and S_COMPLITE.
REQ-011 SHALL leave S_IDLE for S_CHECK on the first cycle StreamEn is high, clearing the byte counter, PixX (0) and row counter.
REQ-012 SHALL in S_CHECK (one cycle, ByteReady=0) go to S_FAIL if PixWidth=0, PixHeight=0, PixWidth>MAX_DIM, PixHeight>MAX_DIM or PixArrayOffset<MIN_OFFSET, else to S_SKIP.
REQ-013 SHALL in S_SKIP hold ByteReady=1, discard bytes and count them, entering S_BYTE_B once PixArrayOffset bytes (file bytes 0..offset-1) are consumed.
REQ-014 SHALL in S_BYTE_B/G/R hold ByteReady=1 and capture B, G, R in that order, advancing only on a transfer.
REQ-015 SHALL assert PixValid in the cycle after the R byte transfers (latency 1), with ByteReady=0 throughout S_PIX_OUT.
REQ-016 SHALL hold PixData, PixX and PixY stable while PixValid=1 and PixReady=0.
REQ-017 SHALL output rows bottom-up: PixY starts at PixHeight-1 and decrements per row; PixX runs 0..PixWidth-1.
REQ-018 SHALL discard PixWidth[1:0] pad bytes per row (pad = (4-(3W mod 4)) mod 4) in S_PAD after the last pixel of each row is accepted; zero pad skips S_PAD.
REQ-019 SHALL enter S_COMPLITE after the pad of the row with PixY=0 is consumed, never requesting bytes beyond it.
REQ-020 SHALL hold StreamComplite (or StreamFail in S_FAIL) high while StreamEn is high, and on StreamEn low clear it and return to S_IDLE.
REQ-021 SHALL, when StreamEn is low in any active state, drop PixValid and ByteReady next cycle and return to S_IDLE with no pixel emitted.
REQ-022 SHALL use a 16-bit byte counter saturating at offset, and 16-bit PixX/row counters with no wrap for legal dimensions.

Reset
REQ-023 SHALL on rst, asynchronously, force S_IDLE, ByteReady=0, PixValid=0, PixData=0, PixX=0, PixY=0, StreamComplite=0 and StreamFail=0.
REQ-024 SHALL on rst mid-stream discard all partial pixel/row state; the next StreamEn restarts from file byte 0.

Structure
REQ-025 SHALL place the state encoding (8-bit localparams) and MIN_OFFSET default in the shared bitmap package, which the header checker also uses.
REQ-026 SHALL be a single module with no sub-module; a pixel FIFO is out of scope.

Verification
REQ-027 SHALL test 2x2 at offset 54 with bytes 54..69 = 01 02 03 04 05 06 AA BB 07 08 09 0A 0B 0C CC DD: pixels (0,1)=030201, (1,1)=060504, (0,0)=090807, (1,0)=0C0B0A; AA BB and CC DD are discarded; then StreamComplite=1 with 70 bytes consumed.
REQ-028 SHALL test 4x1 at offset 54: no S_PAD, 4 pixels, done after exactly 66 bytes.
REQ-029 SHALL test PixArrayOffset=40 (and separately PixWidth=0): StreamFail=1 within 2 cycles of StreamEn, zero bytes consumed, and the flag clears after StreamEn drops.
REQ-030 SHALL test backpressure (PixReady low 5 cycles on the first pixel): PixValid and PixData are held, ByteReady=0, and no byte is lost.
REQ-031 SHALL test StreamEn dropped after the G byte of pixel 3: return to S_IDLE with PixValid=0, and a restart emits pixel (0,H-1) correctly.
REQ-032 SHALL test rst asserted mid-row: outputs are zero immediately, asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/m_bitmap_pixel_stream_pkg.sv
// ---------------------------------------------------------------------------
// m_bitmap_pixel_stream_pkg
// Shared bitmap definitions used by the header checker and the pixel
// streamer: default limits, the 8-bit FSM state encoding and a small helper
// for the per-row pad length of a 24-bit BMP pixel array.
// ---------------------------------------------------------------------------
package m_bitmap_pixel_stream_pkg;

    // Default limits for accepted header fields.
    localparam int unsigned BMP_MIN_OFFSET = 54;
    localparam int unsigned BMP_MAX_DIM    = 1024;

    // Streamer FSM state encoding.
    localparam logic [7:0] S_IDLE     = 8'h00;
    localparam logic [7:0] S_CHECK    = 8'h01;
    localparam logic [7:0] S_SKIP     = 8'h02;
    localparam logic [7:0] S_BYTE_B   = 8'h03;
    localparam logic [7:0] S_BYTE_G   = 8'h04;
    localparam logic [7:0] S_BYTE_R   = 8'h05;
    localparam logic [7:0] S_PIX_OUT  = 8'h06;
    localparam logic [7:0] S_PAD      = 8'h07;
    localparam logic [7:0] S_FAIL     = 8'h08;
    localparam logic [7:0] S_COMPLITE = 8'h09;

    // Rows are padded to a multiple of 4 bytes. With 3 bytes per pixel,
    // (4 - (3W mod 4)) mod 4 reduces to W mod 4, i.e. the low two bits.
    function automatic logic [1:0] row_pad_bytes(input logic [15:0] width);
        return width[1:0];
    endfunction

endpackage

// File: rtl/m_bitmap_pixel_stream_if.sv
// ---------------------------------------------------------------------------
// m_bitmap_pixel_stream_if
// Byte-in / pixel-out stream bundle.
//   ByteValid/ByteData  : file byte stream from the source (byte 0 first)
//   ByteReady           : streamer accepts the current byte
//   PixValid/PixData    : {R,G,B} pixel with coordinates PixX/PixY
//   PixReady            : sink accepts the current pixel
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high; the sender keeps data stable while valid is high and ready low.
// master = byte source + pixel sink side, slave = streamer side.
// ---------------------------------------------------------------------------
interface m_bitmap_pixel_stream_if;
    logic        ByteValid;
    logic [7:0]  ByteData;
    logic        ByteReady;
    logic        PixValid;
    logic [23:0] PixData;
    logic [15:0] PixX;
    logic [15:0] PixY;
    logic        PixReady;

    modport master (
        output ByteValid, ByteData, PixReady,
        input  ByteReady, PixValid, PixData, PixX, PixY
    );

    modport slave (
        input  ByteValid, ByteData, PixReady,
        output ByteReady, PixValid, PixData, PixX, PixY
    );
endinterface

// File: rtl/m_bitmap_pixel_stream.sv
// ---------------------------------------------------------------------------
// m_bitmap_pixel_stream
// Converts a raw 24-bit BMP file byte stream into a pixel stream. After the
// header fields are range-checked, the bytes before the pixel array are
// skipped, then each B,G,R triplet becomes one {R,G,B} pixel tagged with its
// X/Y position. Rows arrive bottom-up, so PixY counts down from Height-1.
// Row pad bytes are consumed and dropped; nothing past the last row's pad is
// requested.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   StreamEn                      start/hold; low aborts and re-arms
//   PixArrayOffset/Width/Height   header fields, stable while StreamEn=1
//   bus                           byte-in / pixel-out handshakes (slave)
//   StreamComplite, StreamFail    done / rejected-parameters flags
//   DbgState                      current FSM state
// ---------------------------------------------------------------------------
module m_bitmap_pixel_stream
    import m_bitmap_pixel_stream_pkg::*;
#(
    parameter int unsigned MAX_DIM    = 'd1024,
    parameter int unsigned MIN_OFFSET = BMP_MIN_OFFSET
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          StreamEn,
    input  logic [15:0]                   PixArrayOffset,
    input  logic [15:0]                   PixWidth,
    input  logic [15:0]                   PixHeight,
    m_bitmap_pixel_stream_if.slave        bus,
    output logic                          StreamComplite,
    output logic                          StreamFail,
    output logic [7:0]                    DbgState
);

    localparam logic [15:0] MAX_DIM_W    = 16'(MAX_DIM);
    localparam logic [15:0] MIN_OFFSET_W = 16'(MIN_OFFSET);

    logic [7:0]  r_state;
    logic [7:0]  w_next_state;
    logic [15:0] r_byte_cnt;
    logic [1:0]  r_pad_cnt;
    logic [7:0]  r_blue;
    logic [7:0]  r_green;
    logic [23:0] r_pix_data;
    logic [15:0] r_pix_x;
    logic [15:0] r_pix_y;

    logic        w_byte_rdy;
    logic        w_pix_valid;
    logic        w_complete;
    logic        w_fail;
    logic        w_byte_xfer;
    logic        w_pix_xfer;
    logic        w_params_bad;
    logic        w_last_x;
    logic        w_last_y;
    logic        w_skip_last;
    logic        w_pad_last;
    logic [1:0]  w_pad;

    assign w_byte_xfer  = bus.ByteValid & w_byte_rdy;
    assign w_pix_xfer   = w_pix_valid & bus.PixReady;
    assign w_params_bad = (PixWidth == 16'd0) || (PixHeight == 16'd0) ||
                          (PixWidth > MAX_DIM_W) || (PixHeight > MAX_DIM_W) ||
                          (PixArrayOffset < MIN_OFFSET_W);
    assign w_pad        = row_pad_bytes(PixWidth);
    assign w_last_x     = (r_pix_x == PixWidth - 16'd1);
    assign w_last_y     = (r_pix_y == 16'd0);
    assign w_skip_last  = (r_byte_cnt == PixArrayOffset - 16'd1);
    assign w_pad_last   = (r_pad_cnt == w_pad - 2'd1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. StreamEn low overrides everything and re-arms.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (StreamEn) w_next_state = S_CHECK;
            end
            S_CHECK: begin
                if (w_params_bad)                  w_next_state = S_FAIL;
                else if (PixArrayOffset == 16'd0)  w_next_state = S_BYTE_B;
                else                               w_next_state = S_SKIP;
            end
            S_SKIP: begin
                if (w_byte_xfer && w_skip_last) w_next_state = S_BYTE_B;
            end
            S_BYTE_B: begin
                if (w_byte_xfer) w_next_state = S_BYTE_G;
            end
            S_BYTE_G: begin
                if (w_byte_xfer) w_next_state = S_BYTE_R;
            end
            S_BYTE_R: begin
                if (w_byte_xfer) w_next_state = S_PIX_OUT;
            end
            S_PIX_OUT: begin
                if (w_pix_xfer) begin
                    if (!w_last_x)          w_next_state = S_BYTE_B;
                    else if (w_pad != 2'd0) w_next_state = S_PAD;
                    else if (w_last_y)      w_next_state = S_COMPLITE;
                    else                    w_next_state = S_BYTE_B;
                end
            end
            S_PAD: begin
                if (w_byte_xfer && w_pad_last) begin
                    w_next_state = w_last_y ? S_COMPLITE : S_BYTE_B;
                end
            end
            S_FAIL:     w_next_state = S_FAIL;
            S_COMPLITE: w_next_state = S_COMPLITE;
            default:    w_next_state = S_IDLE;
        endcase
        if (!StreamEn) w_next_state = S_IDLE;
    end

    // Moore outputs decoded from the registered state, so reset clears them
    // immediately without waiting for a clock edge.
    always_comb begin
        w_byte_rdy  = 1'b0;
        w_pix_valid = 1'b0;
        w_complete  = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            S_SKIP, S_BYTE_B, S_BYTE_G, S_BYTE_R, S_PAD: w_byte_rdy  = 1'b1;
            S_PIX_OUT:                                   w_pix_valid = 1'b1;
            S_FAIL:                                      w_fail      = 1'b1;
            S_COMPLITE:                                  w_complete  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: byte/pad counters, colour capture and pixel coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= 16'd0;
            r_pad_cnt  <= 2'd0;
            r_blue     <= 8'd0;
            r_green    <= 8'd0;
            r_pix_data <= 24'd0;
            r_pix_x    <= 16'd0;
            r_pix_y    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (StreamEn) begin
                        r_byte_cnt <= 16'd0;
                        r_pad_cnt  <= 2'd0;
                        r_pix_x    <= 16'd0;
                        r_pix_y    <= 16'd0;
                    end
                end
                S_CHECK: begin
                    // Bottom row of the image comes first in the file.
                    r_pix_y <= PixHeight - 16'd1;
                end
                S_SKIP: begin
                    if (w_byte_xfer && (r_byte_cnt != PixArrayOffset)) begin
                        r_byte_cnt <= r_byte_cnt + 16'd1;
                    end
                end
                S_BYTE_B: begin
                    if (w_byte_xfer) r_blue <= bus.ByteData;
                end
                S_BYTE_G: begin
                    if (w_byte_xfer) r_green <= bus.ByteData;
                end
                S_BYTE_R: begin
                    if (w_byte_xfer) r_pix_data <= {bus.ByteData, r_green, r_blue};
                end
                S_PIX_OUT: begin
                    r_pad_cnt <= 2'd0;
                    if (w_pix_xfer) begin
                        if (!w_last_x) begin
                            r_pix_x <= r_pix_x + 16'd1;
                        end else begin
                            r_pix_x <= 16'd0;
                            // With pad, the row step happens when the pad ends.
                            if ((w_pad == 2'd0) && !w_last_y) r_pix_y <= r_pix_y - 16'd1;
                        end
                    end
                end
                S_PAD: begin
                    if (w_byte_xfer) begin
                        r_pad_cnt <= r_pad_cnt + 2'd1;
                        if (w_pad_last && !w_last_y) r_pix_y <= r_pix_y - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ByteReady  = w_byte_rdy;
    assign bus.PixValid   = w_pix_valid;
    assign bus.PixData    = r_pix_data;
    assign bus.PixX       = r_pix_x;
    assign bus.PixY       = r_pix_y;
    assign StreamComplite = w_complete;
    assign StreamFail     = w_fail;
    assign DbgState       = r_state;

endmodule

// File: tb/tb_m_bitmap_pixel_stream.sv
// ---------------------------------------------------------------------------
// tb_m_bitmap_pixel_stream
// Directed bench for the BMP pixel streamer. A byte image (header filler,
// pixel triplets, pad bytes, trailing junk) is built per case; the expected
// pixels are pushed to exp_q as the image is built and popped as the DUT
// hands pixels over. Inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_m_bitmap_pixel_stream;
    import m_bitmap_pixel_stream_pkg::*;

    logic        clk;
    logic        rst;
    logic        StreamEn;
    logic [15:0] PixArrayOffset;
    logic [15:0] PixWidth;
    logic [15:0] PixHeight;
    logic        StreamComplite;
    logic        StreamFail;
    logic [7:0]  DbgState;

    m_bitmap_pixel_stream_if bif();

    m_bitmap_pixel_stream dut (
        .clk            (clk),
        .rst            (rst),
        .StreamEn       (StreamEn),
        .PixArrayOffset (PixArrayOffset),
        .PixWidth       (PixWidth),
        .PixHeight      (PixHeight),
        .bus            (bif),
        .StreamComplite (StreamComplite),
        .StreamFail     (StreamFail),
        .DbgState       (DbgState)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mem [0:511];
    int          n_bytes;
    int          byte_idx;
    int          bytes_taken;
    int          exp_bytes;
    int          stall_left;
    bit          stalling;
    bit          gap_en;
    logic [55:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build the file image and the expected pixel list for a W x H picture.
    task automatic build_image(input int w, input int h, input int off);
        int n;
        int c;
        int pad;
        logic [7:0] padv;
        n    = 0;
        c    = 1;
        padv = 8'hAA;
        pad  = (4 - ((3 * w) % 4)) % 4;
        exp_q.delete();
        for (int i = 0; i < off; i++) begin
            mem[n] = 8'(i * 7 + 3);
            n++;
        end
        for (int r = 0; r < h; r++) begin
            for (int x = 0; x < w; x++) begin
                mem[n]     = 8'(c);
                mem[n + 1] = 8'(c + 1);
                mem[n + 2] = 8'(c + 2);
                exp_q.push_back({16'(x), 16'(h - 1 - r), 8'(c + 2), 8'(c + 1), 8'(c)});
                n += 3;
                c += 3;
            end
            for (int p = 0; p < pad; p++) begin
                mem[n] = padv;
                padv   = padv + 8'd1;
                n++;
            end
        end
        exp_bytes = n;
        for (int t = 0; t < 8; t++) begin
            mem[n] = 8'hEE;
            n++;
        end
        n_bytes        = n;
        byte_idx       = 0;
        bytes_taken    = 0;
        PixArrayOffset = 16'(off);
        PixWidth       = 16'(w);
        PixHeight      = 16'(h);
        bif.ByteValid  = 1'b1;
        bif.ByteData   = mem[0];
        bif.PixReady   = 1'b1;
    endtask

    task automatic drive_inputs(input logic fired);
        if (!bif.ByteValid || fired) begin
            bif.ByteValid = (byte_idx < n_bytes) && (!gap_en || ($urandom_range(0, 3) != 0));
            bif.ByteData  = (byte_idx < n_bytes) ? mem[byte_idx] : 8'h00;
        end
        stalling = 1'b0;
        if (bif.PixValid && (stall_left > 0)) begin
            bif.PixReady = 1'b0;
            stall_left--;
            stalling = 1'b1;
        end else begin
            bif.PixReady = gap_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // One clock: called and returns at a falling edge.
    task automatic step();
        logic        bf;
        logic        pf;
        logic [55:0] e;
        bf = bif.ByteValid && bif.ByteReady;
        pf = bif.PixValid && bif.PixReady;
        if (stalling && (exp_q.size() > 0)) begin
            check("stall_pixdata", bif.PixData, exp_q[0][23:0]);
            check("stall_pixvalid", bif.PixValid, 1'b1);
            check("stall_byteready", bif.ByteReady, 1'b0);
        end
        if (pf) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", {bif.PixX, bif.PixY, bif.PixData}, 56'd0 - 56'd1);
            end else begin
                e = exp_q.pop_front();
                check("pixel_xy_rgb", {bif.PixX, bif.PixY, bif.PixData}, e);
            end
        end
        @(posedge clk);
        #1;
        if (bf) begin
            byte_idx++;
            bytes_taken++;
        end
        drive_inputs(bf);
        @(negedge clk);
    endtask

    task automatic run_stream(input string tag);
        int cyc;
        cyc = 0;
        StreamEn = 1'b1;
        while (!StreamComplite && (cyc < 3000)) begin
            step();
            cyc++;
        end
        check({tag, "_complete"}, StreamComplite, 1'b1);
        check({tag, "_bytes"}, 32'(bytes_taken), 32'(exp_bytes));
        check({tag, "_pixels_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_no_more_bytes"}, bif.ByteReady, 1'b0);
        StreamEn = 1'b0;
        step();
        check({tag, "_complete_clear"}, StreamComplite, 1'b0);
        check({tag, "_idle"}, DbgState, S_IDLE);
    endtask

    task automatic fail_case(input string tag, input int w, input int h, input int off);
        build_image(w, h, off);
        exp_q.delete();
        StreamEn = 1'b1;
        step();
        step();
        check({tag, "_fail"}, StreamFail, 1'b1);
        check({tag, "_bytes"}, 32'(bytes_taken), 32'd0);
        StreamEn = 1'b0;
        step();
        check({tag, "_fail_clear"}, StreamFail, 1'b0);
        check({tag, "_idle"}, DbgState, S_IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        rst            = 1'b1;
        StreamEn       = 1'b0;
        PixArrayOffset = 16'd0;
        PixWidth       = 16'd0;
        PixHeight      = 16'd0;
        bif.ByteValid  = 1'b0;
        bif.ByteData   = 8'd0;
        bif.PixReady   = 1'b1;
        n_bytes        = 0;
        byte_idx       = 0;
        bytes_taken    = 0;
        exp_bytes      = 0;
        stall_left     = 0;
        stalling       = 1'b0;
        gap_en         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", DbgState, S_IDLE);
        check("rst_byteready", bif.ByteReady, 1'b0);
        check("rst_pixvalid", bif.PixValid, 1'b0);
        check("rst_pixdata", bif.PixData, 24'd0);
        check("rst_pixx", bif.PixX, 16'd0);
        check("rst_pixy", bif.PixY, 16'd0);
        check("rst_flags", {StreamComplite, StreamFail}, 2'b00);
        rst = 1'b0;
        step();

        // 2x2 with two pad bytes per row.
        build_image(2, 2, 54);
        check("img2x2_size", 32'(exp_bytes), 32'd70);
        run_stream("s2x2");

        // 4x1, no pad.
        build_image(4, 1, 54);
        run_stream("s4x1");

        // 3x2 with three pad bytes per row, random valid/ready gaps.
        gap_en = 1'b1;
        build_image(3, 2, 60);
        run_stream("s3x2_gaps");
        gap_en = 1'b0;

        // Backpressure on the first pixel.
        build_image(2, 2, 54);
        stall_left = 5;
        run_stream("s_backpressure");

        // Rejected parameters.
        fail_case("f_offset40", 2, 2, 40);
        fail_case("f_width0", 0, 2, 54);

        // Abort after the G byte of pixel 3, then restart from byte 0.
        build_image(2, 2, 54);
        StreamEn = 1'b1;
        cyc = 0;
        while ((bytes_taken < 64) && (cyc < 3000)) begin
            step();
            cyc++;
        end
        check("drop_bytes_reached", 32'(bytes_taken), 32'd64);
        StreamEn      = 1'b0;
        bif.ByteValid = 1'b0;
        exp_q.delete();
        step();
        check("drop_pixvalid", bif.PixValid, 1'b0);
        check("drop_byteready", bif.ByteReady, 1'b0);
        check("drop_idle", DbgState, S_IDLE);
        step();
        check("drop_no_extra_byte", 32'(bytes_taken), 32'd64);
        build_image(2, 2, 54);
        run_stream("s_restart");

        // Asynchronous reset mid-row.
        build_image(2, 2, 54);
        StreamEn = 1'b1;
        cyc = 0;
        while ((bytes_taken < 58) && (cyc < 3000)) begin
            step();
            cyc++;
        end
        check("rst_mid_bytes_reached", 32'(bytes_taken), 32'd58);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", DbgState, S_IDLE);
        check("arst_byteready", bif.ByteReady, 1'b0);
        check("arst_pixvalid", bif.PixValid, 1'b0);
        check("arst_pixdata", bif.PixData, 24'd0);
        check("arst_pixx", bif.PixX, 16'd0);
        check("arst_pixy", bif.PixY, 16'd0);
        StreamEn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        build_image(2, 2, 54);
        run_stream("s_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
